// File: rtl/qif_pkg.sv
// Shared widths, neuron constants and the saturating clamp for the QIF neuron.
// Optional feature macro: QIF_REFRACTORY_EN (refractory hold after each spike).
package qif_pkg;

    localparam int V_W    = 8;
    localparam int I_W    = 8;
    localparam int ACC_W  = 18;
    localparam int QSHIFT = 5;
    localparam int REF_W  = 3;

    localparam logic [V_W-1:0]   V_CRIT  = 8'd64;
    localparam logic [V_W-1:0]   V_PEAK  = 8'd240;
    localparam logic [V_W-1:0]   V_RESET = 8'd0;
    localparam logic [REF_W-1:0] REFRAC  = 3'd4;

    // Saturate a signed accumulator into the 0..255 membrane range.
    function automatic logic [V_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] s);
        logic [V_W-1:0] r;
        if (s < 0)
            r = '0;
        else if (s > 18'sd255)
            r = 8'hFF;
        else
            r = s[V_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/qif_update.sv
// Combinational QIF membrane update: V' = V + ((V*(V-V_CRIT)) >>> QSHIFT) + I,
// clamped to 8 bits, with the fire decision taken on the clamped sum.
module qif_update
    import qif_pkg::*;
(
    input  logic [V_W-1:0] v,
    input  logic [I_W-1:0] i_in,
    output logic [V_W-1:0] v_next,
    output logic           fire
);

    logic signed [8:0]       d;
    logic signed [16:0]      v_ext;
    logic signed [16:0]      d_ext;
    logic signed [16:0]      p;
    logic signed [16:0]      q;
    logic signed [ACC_W-1:0] s;
    logic [V_W-1:0]          s_clamped;

    // Quadratic term, floor-shifted, plus leak-free integration of the input current.
    always_comb begin
        d         = $signed({1'b0, v}) - $signed({1'b0, V_CRIT});
        v_ext     = $signed({9'b0, v});
        d_ext     = {{8{d[8]}}, d};
        p         = v_ext * d_ext;
        q         = p >>> QSHIFT;
        s         = {{(ACC_W-17){q[16]}}, q}
                  + $signed({{(ACC_W-V_W){1'b0}}, v})
                  + $signed({{(ACC_W-I_W){1'b0}}, i_in});
        s_clamped = clamp_u8(s);
        fire      = (s_clamped >= V_PEAK);
        v_next    = fire ? V_RESET : s_clamped;
    end

endmodule

// File: rtl/tt_um_qif_neuron.sv
// TinyTapeout tile: one QIF neuron with registered membrane, spike flag and
// 8-bit wrapping spike counter. Optional macro QIF_REFRACTORY_EN adds a
// REFRAC-cycle hold at V_RESET after each spike.
// Note: rst_n is active-HIGH synchronous reset (TT pin name kept).
module tt_um_qif_neuron
    import qif_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [V_W-1:0] v_q, v_d;
    logic           spike_q, spike_d;
    logic [7:0]     count_q, count_d;
    logic [V_W-1:0] v_upd;
    logic           fire;
    logic           unused_uio;

`ifdef QIF_REFRACTORY_EN
    logic [REF_W-1:0] refrac_q, refrac_d;
`endif

    assign unused_uio = &{1'b0, uio_in};

    qif_update u_update (
        .v      (v_q),
        .i_in   (ui_in),
        .v_next (v_upd),
        .fire   (fire)
    );

    // Next-state selection: hold when disabled, otherwise integrate or fire.
    always_comb begin
        v_d     = v_q;
        spike_d = spike_q;
        count_d = count_q;
`ifdef QIF_REFRACTORY_EN
        refrac_d = refrac_q;
`endif
        if (ena) begin
`ifdef QIF_REFRACTORY_EN
            if (refrac_q != '0) begin
                v_d      = V_RESET;
                spike_d  = 1'b0;
                refrac_d = refrac_q - 1'b1;
            end else begin
                v_d     = v_upd;
                spike_d = fire;
                if (fire) begin
                    count_d  = count_q + 8'd1;
                    refrac_d = REFRAC;
                end
            end
`else
            v_d     = v_upd;
            spike_d = fire;
            if (fire)
                count_d = count_q + 8'd1;
`endif
        end
    end

    // State registers; reset wins over ena on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            v_q     <= V_RESET;
            spike_q <= 1'b0;
            count_q <= '0;
`ifdef QIF_REFRACTORY_EN
            refrac_q <= '0;
`endif
        end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
            count_q <= count_d;
`ifdef QIF_REFRACTORY_EN
            refrac_q <= refrac_d;
`endif
        end
    end

    assign uo_out  = {spike_q, v_q[7:1]};
    assign uio_out = count_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_qif_neuron.sv
// Directed self-checking bench for tt_um_qif_neuron.
module tb_tt_um_qif_neuron;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_um_qif_neuron dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Independent integer model of one enabled update (floor via signed >>>).
    function automatic int model_next(input int v, input int i, output bit f);
        int p;
        int s;
        p = v * (v - 64);
        s = v + (p >>> 5) + i;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        f = (s >= 240);
        return f ? 0 : s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
    endtask

    int         exp_v2 [8] = '{10, 3, 7, 4, 6, 5, 5, 5};
    int         v_m;
    int         rc_m;
    int         cnt_m;
    int         pulses;
    bit         f_m;
    logic [7:0] vb;
    logic [7:0] exp_uo;
    logic [7:0] frz_uo;
    logic [7:0] frz_cnt;

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'd0;
        uio_in = 8'hA5;

        // 1: reset and quiescence at I=0
        step();
        step();
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_cnt", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_uo", uo_out, 8'h00);
        end
        chk("idle_cnt", uio_out, 8'h00);

        // 2: I=10 settles at V=5 with no spikes
        ui_in = 8'd10;
        for (int k = 0; k < 8; k++) begin
            step();
            vb = 8'(exp_v2[k]);
            chk("settle_uo", uo_out, {1'b0, vb[7:1]});
        end
        for (int k = 0; k < 10; k++) step();
        chk("settle_hold", uo_out, 8'h02);
        chk("settle_cnt", uio_out, 8'h00);

        // 3 / 6: I=255 from V=0, continuous firing and counter wrap
        ui_in = 8'd0;
        do_reset();
        ui_in = 8'd255;
`ifdef QIF_REFRACTORY_EN
        for (int c = 1; c <= 1280; c++) begin
            step();
            if (c <= 12 || c >= 1270) begin
                chk("refr_uo", uo_out, (((c - 1) % 5) == 0) ? 8'h80 : 8'h00);
                chk("refr_cnt", uio_out, 8'(((c + 4) / 5) % 256));
            end
        end
        chk("refr_wrap", uio_out, 8'h00);
`else
        for (int c = 1; c <= 256; c++) begin
            step();
            if (c <= 5 || c >= 254) begin
                chk("fire_uo", uo_out, 8'h80);
                chk("fire_cnt", uio_out, 8'(c % 256));
            end
        end
        chk("fire_wrap", uio_out, 8'h00);
`endif

        // 5: ena=0 freezes, reset mid-run clears
        do_reset();
        ui_in = 8'd255;
        step();
        step();
        step();
`ifdef QIF_REFRACTORY_EN
        frz_uo  = 8'h00;
        frz_cnt = 8'h01;
`else
        frz_uo  = 8'h80;
        frz_cnt = 8'h03;
`endif
        chk("pre_frz_uo", uo_out, frz_uo);
        chk("pre_frz_cnt", uio_out, frz_cnt);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("frz_uo", uo_out, frz_uo);
            chk("frz_cnt", uio_out, frz_cnt);
        end
        ena = 1'b1;
        step();
`ifdef QIF_REFRACTORY_EN
        chk("resume_uo", uo_out, 8'h00);
        step();
        chk("resume_uo2", uo_out, 8'h00);
        step();
        chk("resume_spk", uo_out, 8'h80);
        chk("resume_cnt", uio_out, 8'h02);
`else
        chk("resume_uo", uo_out, 8'h80);
        chk("resume_cnt", uio_out, 8'h04);
`endif
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        chk("midrst_uo", uo_out, 8'h00);
        chk("midrst_cnt", uio_out, 8'h00);
        chk("midrst_oe", uio_oe, 8'hFF);

        // 4: I=40 periodic firing against the integer model
        ui_in = 8'd0;
        do_reset();
        ui_in  = 8'd40;
        v_m    = 0;
        rc_m   = 0;
        cnt_m  = 0;
        pulses = 0;
        for (int k = 0; k < 200; k++) begin
            step();
`ifdef QIF_REFRACTORY_EN
            if (rc_m != 0) begin
                rc_m--;
                v_m = 0;
                f_m = 1'b0;
            end else begin
                v_m = model_next(v_m, 40, f_m);
                if (f_m) rc_m = 4;
            end
`else
            v_m = model_next(v_m, 40, f_m);
`endif
            if (f_m) cnt_m++;
            if (uo_out[7]) pulses++;
            vb     = 8'(v_m);
            exp_uo = {f_m, vb[7:1]};
            chk("i40_uo", uo_out, exp_uo);
            chk("i40_cnt", uio_out, 8'(cnt_m % 256));
        end
        chk("i40_pulses", uio_out, 8'(pulses % 256));
        chk("i40_fired", (cnt_m > 1) ? 8'h01 : 8'h00, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
